apb_rr_master: RTL and testbench

//  APB master that lets NUM_REQ internal requesters share one APB slave (the 32-word apb RAM).

---
 rtl/apb_rr_pkg.sv | 20 ++
 rtl/apb_rr_arbiter.sv | 36 +++
 rtl/apb_rr_master.sv | 195 +++++++++++++++++++
 tb/tb_apb_rr_master.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg: shared types and defaults for the round-robin APB master.
// Provides the FSM state enum, default widths and the index-width helper.
package apb_rr_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TMO_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational rotating-priority picker.
// In: req_mask, ptr. Out: gnt_oh (one-hot), gnt_idx, valid (any request).
module apb_rr_arbiter
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDXW    = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDXW-1:0]    gnt_idx,
  output logic               valid
);

  // Scan from ptr upward with wrap; first set bit wins.
  always_comb begin
    int j;
    logic [IDXW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      jj = IDXW'(j);
      if (!valid && req_mask[jj]) begin
        valid      = 1'b1;
        gnt_oh[jj] = 1'b1;
        gnt_idx    = jj;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: NUM_REQ requesters share one APB slave, round-robin.
// Ports: pclk/presetn (sync, active-low); req*/gnt/done/rsp_* client side;
// psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr APB side.
// Optional ACCESS timeout built when APB_TIMEOUT_EN is defined.
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = DEF_TMO_CYC
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IDXW = idx_w(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [AW-1:0]        paddr_q, paddr_d;
  logic [DW-1:0]        pwdata_q, pwdata_d;

  logic [NUM_REQ-1:0]   arb_mask;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDXW-1:0]      arb_idx;
  logic                 arb_valid;
  logic [AW-1:0]        addr_a [NUM_REQ];
  logic [DW-1:0]        wdata_a [NUM_REQ];
  logic                 fin;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
    end
  end

  // The requester just completed still shows req during its done cycle.
  assign arb_mask = req & ~done_q;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .req_mask (arb_mask),
    .ptr      (ptr_q),
    .gnt_oh   (arb_oh),
    .gnt_idx  (arb_idx),
    .valid    (arb_valid)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  always_comb begin
    tmo_d = '0;
    if (state_q == ST_ACCESS) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk) begin
    if (!presetn) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  // Limit has no effect without the counter.
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    fin       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d    = arb_idx;
          gnt_d    = arb_oh;
          pwrite_d = req_write[arb_idx];
          paddr_d  = addr_a[arb_idx];
          pwdata_d = wdata_a[arb_idx];
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          fin   = 1'b1;
          err_d = pslverr;
          if (!pwrite_q) rdata_d = prdata;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_hit) begin
          fin     = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      done_d    = gnt_q;
      ptr_d     = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      gnt_d     = '0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed and randomized checks of apb_rr_master
// against a 32-word APB RAM model and a round-robin reference model.
module tb_apb_rr_master;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic              presetn;
  logic [NR-1:0]     req, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt, done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err, psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata, prdata;
  logic              pready, pslverr;

  apb_rr_master #(
    .NUM_REQ (NR), .AW (AW), .DW (DW), .TIMEOUT_CYC (TMO)
  ) dut (
    .pclk (pclk), .presetn (presetn),
    .req (req), .req_write (req_write),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .gnt (gnt), .done (done),
    .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
    .psel (psel), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .prdata (prdata),
    .pready (pready), .pslverr (pslverr)
  );

  int tests = 0;
  int fails = 0;

  // APB RAM slave
  logic [31:0] mem [32];
  logic [31:0] m_mem [32];
  int   stall_q   = 0;
  int   max_stall = 0;
  bit   tie_low   = 1'b0;
  bit   bd_we     = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic in_rng;

  assign in_rng  = (paddr < 32);
  assign pready  = !tie_low && (stall_q == 0);
  assign prdata  = (psel && in_rng) ? mem[paddr[4:0]] : 32'h0;
  assign pslverr = psel && penable && !in_rng;

  always @(posedge pclk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (psel && !penable)
      stall_q <= (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
    else if (psel && penable && stall_q > 0)
      stall_q <= stall_q - 1;
    if (psel && penable && pready && pwrite && in_rng)
      mem[paddr[4:0]] <= pwdata;
  end

  int m_ptr = 0;

  function automatic int rr_pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < NR; k++)
      if (p[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req[i]                = 1'b1;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    logic [31:0] av;
    av      = a;
    bd_addr = av[4:0];
    bd_data = d;
    bd_we   = 1'b1;
    m_mem[a] = d;
    @(negedge pclk);
    bd_we = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic [3:0] d);
    d = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge pclk);
      if (done != 0) begin
        d = done;
        break;
      end
    end
    if (d == 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    req     = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    m_ptr   = 0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    presetn = 1'b0;
    req     = '1;
    repeat (2) @(negedge pclk);
    tests++;
    if ({psel, penable, pwrite, gnt, done, rsp_err} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0",
               {psel, penable, pwrite, gnt, done, rsp_err});
    end
    tests++;
    if (rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
    end
    tests++;
    if ({paddr, pwdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_bus: got %h/%h want 0", paddr, pwdata);
    end
    presetn = 1'b1;
    req     = '0;
    @(negedge pclk);
    tests++;
    if (psel !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: psel %b want 0", psel);
    end
    m_ptr = 0;
  endtask

  task automatic test_single_read();
    poke(5, 32'hA5A5_A5A5);
    set_req(0, 1'b0, 32'd5, 32'h0);
    @(negedge pclk);
    tests++;
    if ({psel, penable} !== 2'b10) begin
      fails++;
      $display("FAIL rd_setup: psel/penable %b want 10", {psel, penable});
    end
    tests++;
    if (gnt !== 4'b0001 || paddr !== 32'd5 || pwrite !== 1'b0) begin
      fails++;
      $display("FAIL rd_setup_bus: gnt %b addr %0d wr %b want 0001 5 0",
               gnt, paddr, pwrite);
    end
    @(negedge pclk);
    tests++;
    if ({psel, penable} !== 2'b11) begin
      fails++;
      $display("FAIL rd_access: psel/penable %b want 11", {psel, penable});
    end
    @(negedge pclk);
    tests++;
    if (done !== 4'b0001 || psel !== 1'b0) begin
      fails++;
      $display("FAIL rd_done: done %b psel %b want 0001 0", done, psel);
    end
    tests++;
    if (rsp_rdata !== 32'hA5A5_A5A5 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL rd_data: %h err %b want a5a5a5a5 0", rsp_rdata, rsp_err);
    end
    // req held through the done cycle must not reissue
    @(negedge pclk);
    tests++;
    if ({psel, done} !== 5'b0) begin
      fails++;
      $display("FAIL rd_no_reissue: psel %b done %b want 0", psel, done);
    end
    req[0] = 1'b0;
    m_ptr  = 1;
    @(negedge pclk);
  endtask

  task automatic test_write_read();
    logic [3:0] d;
    bit bad, seen;
    max_stall = 3;
    bad  = 1'b0;
    seen = 1'b0;
    d    = '0;
    set_req(2, 1'b1, 32'd31, 32'hDEAD_BEEF);
    for (int c = 0; c < 30; c++) begin
      @(negedge pclk);
      if (done != 0) begin
        d = done;
        break;
      end
      if (psel) begin
        seen = 1'b1;
        if (paddr !== 32'd31 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1)
          bad = 1'b1;
      end
    end
    tests++;
    if (d !== 4'b0100) begin
      fails++;
      $display("FAIL wr_done: done %b want 0100", d);
    end
    tests++;
    if (bad || !seen) begin
      fails++;
      $display("FAIL wr_stable: bad %b seen %b want 0 1", bad, seen);
    end
    tests++;
    if (rsp_rdata !== 32'hA5A5_A5A5 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL wr_rsp: %h err %b want a5a5a5a5 0", rsp_rdata, rsp_err);
    end
    m_mem[31] = 32'hDEAD_BEEF;
    req[2] = 1'b0;
    @(negedge pclk);
    set_req(2, 1'b0, 32'd31, 32'h0);
    wait_done(20, d);
    tests++;
    if (d !== 4'b0100 || rsp_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rdback: done %b data %h want 0100 deadbeef", d, rsp_rdata);
    end
    req[2]    = 1'b0;
    m_ptr     = 3;
    max_stall = 0;
  endtask

  task automatic test_fairness();
    logic [3:0] d;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    for (int a = 10; a < 14; a++) poke(a, $urandom);
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'(10 + i), 32'h0);
    for (int t = 0; t < 5; t++) begin
      wait_done(30, d);
      tests++;
      if (d !== (4'b1 << exp_ord[t])) begin
        fails++;
        $display("FAIL fair_order[%0d]: done %b want %0d", t, d, exp_ord[t]);
      end
      tests++;
      if ({psel, penable} !== 2'b00) begin
        fails++;
        $display("FAIL fair_idle[%0d]: psel/penable %b want 00",
                 t, {psel, penable});
      end
      tests++;
      if (rsp_rdata !== m_mem[10 + exp_ord[t]]) begin
        fails++;
        $display("FAIL fair_data[%0d]: %h want %h",
                 t, rsp_rdata, m_mem[10 + exp_ord[t]]);
      end
      if (t != 0) req[exp_ord[t]] = 1'b0;
    end
    m_ptr = 1;
  endtask

  task automatic test_error();
    logic [3:0] d;
    set_req(1, 1'b0, 32'd40, 32'h0);
    wait_done(20, d);
    tests++;
    if (d !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL err_rsp: done %b err %b data %h want 0010 1 0",
               d, rsp_err, rsp_rdata);
    end
    req[1] = 1'b0;
    m_ptr  = 2;
    @(negedge pclk);
    set_req(0, 1'b0, 32'd10, 32'h0);
    set_req(2, 1'b0, 32'd11, 32'h0);
    @(negedge pclk);
    tests++;
    if (gnt !== 4'b0100) begin
      fails++;
      $display("FAIL err_ptr: gnt %b want 0100", gnt);
    end
    wait_done(20, d);
    req[2] = 1'b0;
    wait_done(20, d);
    tests++;
    if (d !== 4'b0001) begin
      fails++;
      $display("FAIL err_pending: done %b want 0001", d);
    end
    req[0] = 1'b0;
    m_ptr  = 1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] d;
    bit nd;
    tie_low = 1'b1;
    set_req(2, 1'b0, 32'd12, 32'h0);
    repeat (2) @(negedge pclk);
    tests++;
    if ({psel, penable} !== 2'b11) begin
      fails++;
      $display("FAIL rst_mid_access: psel/penable %b want 11", {psel, penable});
    end
    presetn = 1'b0;
    req     = '0;
    @(negedge pclk);
    tests++;
    if ({psel, penable, gnt, done} !== '0) begin
      fails++;
      $display("FAIL rst_mid_abort: %b want 0", {psel, penable, gnt, done});
    end
    presetn = 1'b1;
    tie_low = 1'b0;
    m_ptr   = 0;
    nd      = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (done != 0) nd = 1'b1;
    end
    tests++;
    if (nd) begin
      fails++;
      $display("FAIL rst_mid_nodone: done seen 1 want 0");
    end
    set_req(0, 1'b0, 32'd10, 32'h0);
    set_req(3, 1'b0, 32'd13, 32'h0);
    @(negedge pclk);
    tests++;
    if (gnt !== 4'b0001) begin
      fails++;
      $display("FAIL rst_mid_ptr: gnt %b want 0001", gnt);
    end
    wait_done(20, d);
    req[0] = 1'b0;
    wait_done(20, d);
    req[3] = 1'b0;
    m_ptr  = 0;
  endtask

  task automatic test_timeout();
    logic [3:0] d;
    int acc;
    poke(3, 32'h3C3C_0001);
    tie_low = 1'b1;
    set_req(3, 1'b0, 32'd3, 32'h0);
    acc = 0;
    d   = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (done != 0) begin
        d = done;
        break;
      end
      if (penable) acc++;
    end
`ifdef APB_TIMEOUT_EN
    tests++;
    if (d !== 4'b1000 || acc != TMO) begin
      fails++;
      $display("FAIL tmo_done: done %b after %0d access want 1000 after %0d",
               d, acc, TMO);
    end
    tests++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL tmo_rsp: err %b data %h want 1 0", rsp_err, rsp_rdata);
    end
    tie_low = 1'b0;
`else
    tests++;
    if (d !== 4'b0000) begin
      fails++;
      $display("FAIL notmo_done: done %b want 0000", d);
    end
    tests++;
    if ({psel, penable} !== 2'b11) begin
      fails++;
      $display("FAIL notmo_hold: psel/penable %b want 11", {psel, penable});
    end
    tie_low = 1'b0;
    wait_done(5, d);
    tests++;
    if (d !== 4'b1000 || rsp_err !== 1'b0 || rsp_rdata !== 32'h3C3C_0001) begin
      fails++;
      $display("FAIL notmo_late: done %b err %b data %h want 1000 0 3c3c0001",
               d, rsp_err, rsp_rdata);
    end
`endif
    req[3] = 1'b0;
    m_ptr  = 0;
    @(negedge pclk);
  endtask

  task automatic test_random();
    bit          act [NR];
    bit          w   [NR];
    logic [31:0] ad  [NR];
    logic [31:0] wd  [NR];
    logic [31:0] m_rdata;
    logic [31:0] exp_rd;
    logic [3:0]  p_req, p_done, p_gnt, pend, expg, expd;
    bit          exp_err;
    int          owner, e, left;
    for (int a = 0; a < 32; a++) poke(a, $urandom);
    do_reset();
    max_stall = 2;
    m_rdata   = '0;
    owner     = -1;
    p_req     = '0;
    p_done    = '0;
    p_gnt     = '0;
    for (int i = 0; i < NR; i++) act[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge pclk);
      if (p_gnt == 0) begin
        pend = p_req & ~p_done;
        e    = rr_pick(pend, m_ptr);
        expg = (e < 0) ? 4'b0 : (4'b1 << e);
        tests++;
        if (gnt !== expg) begin
          fails++;
          $display("FAIL rnd_gnt@%0d: gnt %b want %b", cyc, gnt, expg);
        end
        if (e >= 0) owner = e;
      end
      if (done != 0) begin
        expd = (owner < 0) ? 4'b0 : (4'b1 << owner);
        tests++;
        if (done !== expd) begin
          fails++;
          $display("FAIL rnd_done@%0d: done %b want %b", cyc, done, expd);
        end
        if (owner >= 0) begin
          exp_err = (ad[owner] >= 32);
          if (w[owner]) begin
            if (!exp_err) m_mem[ad[owner]] = wd[owner];
          end else begin
            m_rdata = exp_err ? 32'h0 : m_mem[ad[owner]];
          end
          exp_rd = m_rdata;
          tests++;
          if (rsp_err !== exp_err || rsp_rdata !== exp_rd) begin
            fails++;
            $display("FAIL rnd_rsp@%0d: err %b data %h want %b %h",
                     cyc, rsp_err, rsp_rdata, exp_err, exp_rd);
          end
          act[owner] = 1'b0;
          req[owner] = 1'b0;
          m_ptr      = (owner + 1) % NR;
          owner      = -1;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (!act[i] && !done[i] && cyc < 360 && $urandom_range(99, 0) < 30) begin
          act[i] = 1'b1;
          w[i]   = 1'($urandom_range(1, 0));
          ad[i]  = 32'($urandom_range(39, 0));
          wd[i]  = $urandom;
          set_req(i, w[i], ad[i], wd[i]);
        end else if (act[i] && owner != i && gnt != 0 &&
                     $urandom_range(99, 0) < 5) begin
          act[i] = 1'b0;
          req[i] = 1'b0;
        end
      end
      p_req  = req;
      p_done = done;
      p_gnt  = gnt;
    end
    left = 0;
    for (int i = 0; i < NR; i++) if (act[i]) left++;
    tests++;
    if (left != 0) begin
      fails++;
      $display("FAIL rnd_drain: %0d requests unserved want 0", left);
    end
    max_stall = 0;
  endtask

  initial begin
    presetn   = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_fairness();
    test_error();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
